// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV64 memory responder: boot FSM state
// encoding, the canonical NOP instruction and address-index width helper.
package riscv_mem_pkg;

  // Boot/run state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Number of index bits needed to address a memory of the given depth
  function automatic int idx_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_boot_loader.sv
// Boot sequencer: IDLE -> LOAD (host streams program words) -> RUN.
// Owns the load pointer and the registered load_ready/core_reset/running
// outputs. The final accepted word (load_last, or the last imem slot)
// releases the core on the same edge that writes it.
module mem_boot_loader
  import riscv_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int IAW        = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_load_valid,
  input  logic           i_load_last,
  output logic           o_load_ready,
  output logic           o_core_reset,
  output logic           o_running,
  output logic           o_imem_we,
  output logic [IAW-1:0] o_imem_waddr,
  output logic [1:0]     o_state
);

  logic [1:0]     r_state;
  logic [IAW-1:0] r_load_ptr;
  logic           r_load_ready;
  logic           r_core_reset;
  logic           r_running;

  logic w_xfer;
  logic w_last_slot;
  logic w_finish;

  // load_ready is only ever high in LOAD, so a transfer implies LOAD
  assign w_xfer      = i_load_valid & r_load_ready;
  assign w_last_slot = (r_load_ptr == IAW'(IMEM_WORDS - 1));
  assign w_finish    = w_xfer & (i_load_last | w_last_slot);

  // Boot FSM with load pointer and registered handshake/core-control outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_load_ptr   <= {IAW{1'b0}};
      r_load_ready <= 1'b0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_LOAD;
          r_load_ready <= 1'b1;
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_load_ptr <= r_load_ptr + IAW'(1);
            if (w_finish) begin
              r_state      <= ST_RUN;
              r_load_ready <= 1'b0;
              r_core_reset <= 1'b0;
              r_running    <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          // Unreachable encoding: fall back to a safe, core-held state
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b0;
          r_core_reset <= 1'b1;
          r_running    <= 1'b0;
        end
      endcase
    end
  end

  assign o_load_ready = r_load_ready;
  assign o_core_reset = r_core_reset;
  assign o_running    = r_running;
  assign o_imem_we    = w_xfer;
  assign o_imem_waddr = r_load_ptr;
  assign o_state      = r_state;

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the single-cycle RV64 core: instruction fetch,
// 64-bit data load/store and host-driven program boot.
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned fetch/data
// accesses in a sticky err bit and suppress them; otherwise low address
// bits are simply truncated and err is tied low.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int IMEM_WORDS  = 256,
  parameter int DMEM_DWORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  output logic [31:0] Instruction,
  input  logic [63:0] ALUResult,
  input  logic [63:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] Read_data,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_reset,
  output logic        running,
  output logic        err
);

  localparam int IAW = idx_width(IMEM_WORDS);
  localparam int DAW = idx_width(DMEM_DWORDS);

  logic [31:0] r_imem [IMEM_WORDS];
  logic [63:0] r_dmem [DMEM_DWORDS];

  logic [1:0]     w_state;
  logic           w_run;
  logic           w_imem_we;
  logic [IAW-1:0] w_imem_waddr;

  logic           w_pc_in_range;
  logic [IAW-1:0] w_pc_idx;
  logic           w_d_in_range;
  logic [DAW-1:0] w_d_idx;
  logic           w_pc_mis;
  logic           w_d_mis;
  logic           w_fetch_ok;
  logic           w_data_ok;
  logic           w_store;

  mem_boot_loader #(
    .IMEM_WORDS (IMEM_WORDS),
    .IAW        (IAW)
  ) u_boot (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_load_valid (load_valid),
    .i_load_last  (load_last),
    .o_load_ready (load_ready),
    .o_core_reset (core_reset),
    .o_running    (running),
    .o_imem_we    (w_imem_we),
    .o_imem_waddr (w_imem_waddr),
    .o_state      (w_state)
  );

  assign w_run = (w_state == ST_RUN);

  // Range is "all bits above the index field are zero"
  assign w_pc_in_range = (pc[63:IAW+2] == {(62-IAW){1'b0}});
  assign w_pc_idx      = pc[IAW+1:2];
  assign w_d_in_range  = (ALUResult[63:DAW+3] == {(61-DAW){1'b0}});
  assign w_d_idx       = ALUResult[DAW+2:3];

`ifdef MISALIGN_CHECK_EN
  logic r_err;

  assign w_pc_mis = |pc[1:0];
  assign w_d_mis  = |ALUResult[2:0];

  // Sticky misalignment flag, only armed while the core is live
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_run & (((MemRead | MemWrite) & w_d_mis) | w_pc_mis)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  logic w_unused_lowbits;

  assign w_pc_mis         = 1'b0;
  assign w_d_mis          = 1'b0;
  assign err              = 1'b0;
  assign w_unused_lowbits = ^{pc[1:0], ALUResult[2:0]};
`endif

  assign w_fetch_ok = w_run & w_pc_in_range & ~w_pc_mis;
  assign w_data_ok  = w_run & w_d_in_range & ~w_d_mis;
  assign w_store    = MemWrite & w_data_ok;

  // Program image written by the boot loader; arrays are never cleared
  always_ff @(posedge clk) begin
    if (w_imem_we) begin
      r_imem[w_imem_waddr] <= load_data;
    end
  end

  // Data store; a same-cycle load still sees the pre-edge contents
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_dmem[w_d_idx] <= Write_data;
    end
  end

  // Combinational fetch: NOP whenever the fetch cannot be served
  always_comb begin
    Instruction = NOP_INSN;
    if (w_fetch_ok) begin
      Instruction = r_imem[w_pc_idx];
    end else begin
      Instruction = NOP_INSN;
    end
  end

  // Combinational load data: zero unless a valid in-range load is live
  always_comb begin
    Read_data = 64'h0;
    if (MemRead & w_data_ok) begin
      Read_data = r_dmem[w_d_idx];
    end else begin
      Read_data = 64'h0;
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: randomized boot streams and
// data traffic compared with a behavioural memory/boot model.
module tb_riscv_mem_responder;

  localparam int IMEM_WORDS  = 256;
  localparam int DMEM_DWORDS = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] Instruction;
  logic [63:0] ALUResult;
  logic [63:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] Read_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        core_reset;
  logic        running;
  logic        err;

  riscv_mem_responder #(
    .IMEM_WORDS  (IMEM_WORDS),
    .DMEM_DWORDS (DMEM_DWORDS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .Instruction (Instruction),
    .ALUResult   (ALUResult),
    .Write_data  (Write_data),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Read_data   (Read_data),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .core_reset  (core_reset),
    .running     (running),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: memory contents persist across resets
  logic [31:0] m_imem   [IMEM_WORDS];
  bit          m_ivalid [IMEM_WORDS];
  logic [63:0] m_dmem   [DMEM_DWORDS];
  bit          m_dvalid [DMEM_DWORDS];
  int          m_ptr;
  bit          m_started;
  bit          m_ready;
  bit          m_run;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'h0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUResult  = 64'h0;
    Write_data = 64'h0;
    pc         = 64'h0;
    tick;
    check("rst_core_reset", core_reset, 64'd1);
    check("rst_running", running, 64'd0);
    check("rst_load_ready", load_ready, 64'd0);
    check("rst_err", err, 64'd0);
    check("rst_insn", Instruction, NOP);
    tick;
    reset     = 1'b0;
    m_ptr     = 0;
    m_started = 1'b0;
    m_ready   = 1'b0;
    m_run     = 1'b0;
    m_err     = 1'b0;
  endtask

  // One clock of the host load port, then compare the boot outputs
  task automatic boot_cycle(input bit v, input logic [31:0] d, input bit last);
    load_valid = v;
    load_data  = d;
    load_last  = last;
    tick;
    if (v && m_ready) begin
      m_imem[m_ptr]   = d;
      m_ivalid[m_ptr] = 1'b1;
      m_ptr++;
      if (last || m_ptr == IMEM_WORDS) begin
        m_run   = 1'b1;
        m_ready = 1'b0;
      end
    end
    if (!m_started) begin
      m_started = 1'b1;
      m_ready   = 1'b1;
    end
    check("boot_running", running, 64'(m_run));
    check("boot_core_reset", core_reset, 64'(!m_run));
    check("boot_load_ready", load_ready, 64'(m_ready));
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Stream words until RUN; last_idx < 0 means load_last is never raised
  task automatic boot(input bit rand_valid, input int last_idx);
    int cyc = 0;
    while (!m_run && cyc < IMEM_WORDS * 4 + 16) begin
      boot_cycle(rand_valid ? 1'($urandom_range(0, 1)) : 1'b1, $urandom,
                 (last_idx >= 0) && (m_ptr == last_idx));
      cyc++;
    end
    check("boot_done", running, 64'd1);
  endtask

  task automatic pc_check(input logic [63:0] a);
    int idx;
    bit ok;
    pc  = a;
    #1;
    idx = int'((a >> 2) % IMEM_WORDS);
    ok  = m_run && (a < 64'(IMEM_WORDS * 4)) && !(MIS_EN && a[1:0] != 2'b00);
    if (!ok) begin
      check("insn_nop", Instruction, NOP);
    end else if (m_ivalid[idx]) begin
      check("insn", Instruction, m_imem[idx]);
    end
    tick;
    if (m_run && MIS_EN && a[1:0] != 2'b00) m_err = 1'b1;
    check("insn_err", err, 64'(m_err));
    pc = 64'h0;
  endtask

  task automatic data_cycle(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wdata);
    bit in_rng;
    bit mis;
    bit ok;
    int idx;
    MemRead    = rd;
    MemWrite   = wr;
    ALUResult  = addr;
    Write_data = wdata;
    #1;
    in_rng = (addr < 64'(DMEM_DWORDS * 8));
    idx    = int'((addr >> 3) % DMEM_DWORDS);
    mis    = MIS_EN && (addr[2:0] != 3'b000);
    ok     = m_run && in_rng && !mis;
    if (rd && ok) begin
      if (m_dvalid[idx]) check("load_data", Read_data, m_dmem[idx]);
    end else begin
      check("load_zero", Read_data, 64'h0);
    end
    tick;
    if (m_run && (rd || wr) && mis) m_err = 1'b1;
    if (wr && ok) begin
      m_dmem[idx]   = wdata;
      m_dvalid[idx] = 1'b1;
    end
    check("data_err", err, 64'(m_err));
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: three words, continuous valid, last on the third
    apply_reset;
    check("ready_before_load", load_ready, 64'd0);
    boot(1'b0, 2);
    check("t1_ptr", 64'(m_ptr), 64'd3);
    pc_check(64'h8);
    pc_check(64'h0);

    // 2: gapped valid; accesses outside RUN are inert
    apply_reset;
    boot_cycle(1'b1, 32'hAAAA_0000, 1'b0);
    boot_cycle(1'b1, $urandom, 1'b0);
    boot_cycle(1'b0, $urandom, 1'b0);
    boot_cycle(1'b1, $urandom, 1'b0);
    check("t2_load_ptr", 64'(dut.u_boot.r_load_ptr), 64'(m_ptr));
    check("t2_ptr_two", 64'(m_ptr), 64'd2);
    data_cycle(1'b1, 1'b1, 64'h10, 64'h1111_2222_3333_4444);
    pc_check(64'h0);
    boot(1'b1, 5);
    for (int i = 0; i < 6; i++) pc_check(64'(i * 4));

    // 4: store/load, read-during-write, then random traffic
    data_cycle(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567);
    data_cycle(1'b1, 1'b0, 64'h10, 64'h0);
    check("t4_model_val", m_dmem[2], 64'hDEAD_BEEF_0123_4567);
    data_cycle(1'b1, 1'b1, 64'h10, 64'hCAFE_F00D_8888_9999);
    data_cycle(1'b1, 1'b0, 64'h10, 64'h0);
    data_cycle(1'b0, 1'b1, 64'h0, 64'h0123_0123_0123_0123);
    for (int i = 0; i < 300; i++) begin
      logic [63:0] a;
      a = 64'($urandom_range(0, 20)) << 3;
      if ($urandom_range(0, 9) == 0) a = 64'(DMEM_DWORDS * 8) + a;
      if ($urandom_range(0, 19) == 0) a = a | (64'h1 << 40);
      if ($urandom_range(0, 9) == 0) a = 64'((DMEM_DWORDS - 1) * 8);
      data_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end

    // 5: out-of-range fetch/load/store
    data_cycle(1'b0, 1'b1, 64'(DMEM_DWORDS * 8), 64'h5555_6666_7777_8888);
    data_cycle(1'b1, 1'b0, 64'(DMEM_DWORDS * 8), 64'h0);
    data_cycle(1'b1, 1'b0, 64'h0, 64'h0);
    data_cycle(1'b1, 1'b0, 64'h1_0000_0000, 64'h0);

    // 3: full image without load_last; post-RUN traffic ignored
    apply_reset;
    boot(1'b1, -1);
    check("t3_ptr_full", 64'(m_ptr), 64'(IMEM_WORDS));
    boot_cycle(1'b1, 32'hBAD0_BAD0, 1'b1);
    for (int i = 0; i < IMEM_WORDS; i++) pc_check(64'(i * 4));
    pc_check(64'(IMEM_WORDS * 4));
    pc_check(64'h1_0000_0000);

    // 6: misaligned store, misaligned fetch, then reset mid-RUN
    data_cycle(1'b0, 1'b1, 64'h10, 64'h0A0A_0B0B_0C0C_0D0D);
    data_cycle(1'b0, 1'b1, 64'h13, 64'h1357_9BDF_2468_ACE0);
    data_cycle(1'b1, 1'b0, 64'h10, 64'h0);
    data_cycle(1'b1, 1'b0, 64'h17, 64'h0);
    pc_check(64'h9);
    pc = 64'h8;
    MemRead   = 1'b1;
    ALUResult = 64'h10;
    #3;
    reset = 1'b1;
    #1;
    check("midrst_err", err, 64'd0);
    check("midrst_core_reset", core_reset, 64'd1);
    check("midrst_running", running, 64'd0);
    check("midrst_insn", Instruction, NOP);
    check("midrst_read", Read_data, 64'h0);
    apply_reset;
    boot(1'b0, 1);
    data_cycle(1'b1, 1'b0, 64'h10, 64'h0);
    data_cycle(1'b1, 1'b0, 64'h0, 64'h0);
    pc_check(64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
